// File: rtl/mha_pkg.sv
// Shared definitions for the multi-head-attention Q.K tile scheduler.
//   SEL_W_DEF : default tile-select width (Q/O and K/V line selects)
//   state_e   : scheduler FSM states
package mha_pkg;

  localparam int unsigned SEL_W_DEF = 6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_HANDOFF = 2'd3
  } state_e;

endpackage : mha_pkg

// File: rtl/mha_qk_scheduler_if.sv
// Bundle of control, pipeline and downstream handshake signals of the scheduler.
//   master : scheduler side (drives o_*, samples i_*)
//   slave  : environment side (host, Q.K pipeline, result consumer)
interface mha_qk_scheduler_if #(
  parameter int unsigned SEL_W = mha_pkg::SEL_W_DEF
);

  // Host control
  logic             i_start;
  logic [SEL_W:0]   i_num_q;
  logic [SEL_W:0]   i_num_k;
  logic             o_busy;
  logic             o_done;
  logic             o_err;

  // Job issue to the Q.K pipeline
  logic             o_qk_ena;
  logic [SEL_W-1:0] o_sel_q_o;
  logic [SEL_W-1:0] o_sel_k_v;

  // Result return from the Q.K pipeline
  logic             i_qk_busy;
  logic             i_qk_vld;
  logic [SEL_W-1:0] i_qk_sel_q_o;
  logic [SEL_W-1:0] i_qk_sel_k_v;
  logic             o_qk_rdy;

  // Result hand-off to downstream
  logic             o_res_vld;
  logic             i_res_rdy;
  logic [SEL_W-1:0] o_res_q;
  logic [SEL_W-1:0] o_res_k;

  modport master (
    input  i_start, i_num_q, i_num_k,
    input  i_qk_busy, i_qk_vld, i_qk_sel_q_o, i_qk_sel_k_v,
    input  i_res_rdy,
    output o_busy, o_done, o_err,
    output o_qk_ena, o_sel_q_o, o_sel_k_v, o_qk_rdy,
    output o_res_vld, o_res_q, o_res_k
  );

  modport slave (
    output i_start, i_num_q, i_num_k,
    output i_qk_busy, i_qk_vld, i_qk_sel_q_o, i_qk_sel_k_v,
    output i_res_rdy,
    input  o_busy, o_done, o_err,
    input  o_qk_ena, o_sel_q_o, o_sel_k_v, o_qk_rdy,
    input  o_res_vld, o_res_q, o_res_k
  );

endinterface : mha_qk_scheduler_if

// File: rtl/mha_tile_idx_cnt.sv
// Q/K tile index counter pair: K is the inner loop, Q the outer loop.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_load             : latch tile counts and clear both indices
//   i_adv              : advance to the next (q,k) pair
//   i_num_q, i_num_k   : tile counts, sampled on i_load
//   o_q_idx, o_k_idx   : current pair (registered)
//   o_last_c           : current pair is (num_q-1, num_k-1)
module mha_tile_idx_cnt
  import mha_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_adv,
  input  logic [SEL_W:0]   i_num_q,
  input  logic [SEL_W:0]   i_num_k,
  output logic [SEL_W-1:0] o_q_idx,
  output logic [SEL_W-1:0] o_k_idx,
  output logic             o_last_c
);

  localparam int unsigned CNT_W = SEL_W + 1;

  logic [CNT_W-1:0] r_num_q;
  logic [CNT_W-1:0] r_num_k;
  logic [SEL_W-1:0] r_q_idx;
  logic [SEL_W-1:0] r_k_idx;
  logic             w_k_wrap;
  logic             w_q_last;

  // Compare at count width so a count of 2**SEL_W still terminates correctly
  assign w_k_wrap = ({1'b0, r_k_idx} == (r_num_k - CNT_W'(1)));
  assign w_q_last = ({1'b0, r_q_idx} == (r_num_q - CNT_W'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num_q <= '0;
      r_num_k <= '0;
      r_q_idx <= '0;
      r_k_idx <= '0;
    end else if (i_load) begin
      r_num_q <= i_num_q;
      r_num_k <= i_num_k;
      r_q_idx <= '0;
      r_k_idx <= '0;
    end else if (i_adv) begin
      if (w_k_wrap) begin
        r_k_idx <= '0;
        r_q_idx <= r_q_idx + SEL_W'(1);
      end else begin
        r_k_idx <= r_k_idx + SEL_W'(1);
      end
    end
  end

  assign o_q_idx  = r_q_idx;
  assign o_k_idx  = r_k_idx;
  assign o_last_c = w_k_wrap & w_q_last;

endmodule : mha_tile_idx_cnt

// File: rtl/mha_qk_scheduler.sv
// Sweeps all (q,k) tile pairs through a Q.K pipeline, one job in flight,
// and hands each result downstream before issuing the next job.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : control / pipeline / downstream bundle (master side)
// o_qk_ena and o_qk_rdy are combinational: the issue pulse has to track the
// live pipeline status, and the result accept mirrors downstream ready.
module mha_qk_scheduler
  import mha_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mha_qk_scheduler_if.master bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_first_job, w_first_nxt;
  logic             r_busy,      w_busy_nxt;
  logic             r_done,      w_done_nxt;
  logic             r_err,       w_err_nxt;
  logic             r_res_vld,   w_res_vld_nxt;
  logic [SEL_W-1:0] r_res_q,     w_res_q_nxt;
  logic [SEL_W-1:0] r_res_k,     w_res_k_nxt;

  logic             w_qk_ena;
  logic             w_qk_rdy;
  logic             w_load;
  logic             w_adv;
  logic             w_zero;
  logic             w_last;
  logic [SEL_W-1:0] w_q_idx;
  logic [SEL_W-1:0] w_k_idx;

  mha_tile_idx_cnt #(
    .SEL_W (SEL_W)
  ) u_idx (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_load),
    .i_adv    (w_adv),
    .i_num_q  (bus.i_num_q),
    .i_num_k  (bus.i_num_k),
    .o_q_idx  (w_q_idx),
    .o_k_idx  (w_k_idx),
    .o_last_c (w_last)
  );

  assign w_zero = (bus.i_num_q == '0) || (bus.i_num_k == '0);

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_first_job <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_res_vld   <= 1'b0;
      r_res_q     <= '0;
      r_res_k     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_first_job <= w_first_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_res_vld   <= w_res_vld_nxt;
      r_res_q     <= w_res_q_nxt;
      r_res_k     <= w_res_k_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_first_nxt   = r_first_job;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_err_nxt     = r_err;
    w_res_vld_nxt = r_res_vld;
    w_res_q_nxt   = r_res_q;
    w_res_k_nxt   = r_res_k;
    w_qk_ena      = 1'b0;
    w_qk_rdy      = 1'b0;
    w_load        = 1'b0;
    w_adv         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // An empty sweep still shows one busy cycle, coincident with done
        w_busy_nxt = 1'b0;
        if (bus.i_start) begin
          w_load      = 1'b1;
          w_err_nxt   = 1'b0;
          w_first_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          if (w_zero) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // Pipeline reports busy/valid out of reset, so the first job skips the check
        if (r_first_job || (!bus.i_qk_busy && !bus.i_qk_vld)) begin
          w_qk_ena    = 1'b1;
          w_first_nxt = 1'b0;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.i_qk_vld && !bus.i_qk_busy) begin
          w_res_vld_nxt = 1'b1;
          w_res_q_nxt   = w_q_idx;
          w_res_k_nxt   = w_k_idx;
          w_err_nxt     = r_err
                        | (bus.i_qk_sel_q_o != w_q_idx)
                        | (bus.i_qk_sel_k_v != w_k_idx);
          w_state_nxt   = S_HANDOFF;
        end
      end

      S_HANDOFF: begin
        w_qk_rdy = bus.i_res_rdy;
        if (r_res_vld && bus.i_res_rdy) begin
          w_res_vld_nxt = 1'b0;
          w_adv         = 1'b1;
          if (w_last) begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Selects come straight from the index registers; indices only move after
  // a result is accepted, which is always between two issues.
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_err     = r_err;
  assign bus.o_qk_ena  = w_qk_ena;
  assign bus.o_sel_q_o = w_q_idx;
  assign bus.o_sel_k_v = w_k_idx;
  assign bus.o_qk_rdy  = w_qk_rdy;
  assign bus.o_res_vld = r_res_vld;
  assign bus.o_res_q   = r_res_q;
  assign bus.o_res_k   = r_res_k;

endmodule : mha_qk_scheduler

// File: tb/tb_mha_qk_scheduler.sv
// Directed bench for mha_qk_scheduler with a fixed-latency Q.K pipeline model.
module tb_mha_qk_scheduler;

  localparam int unsigned SEL_W = 6;
  localparam int          PIPE_LAT = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mha_qk_scheduler_if #(.SEL_W(SEL_W)) bus ();

  mha_qk_scheduler #(.SEL_W(SEL_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Pipeline model: busy/valid out of reset, result PIPE_LAT cycles after issue
  logic corrupt = 1'b0;
  int   pipe_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.i_qk_busy    <= 1'b1;
      bus.i_qk_vld     <= 1'b1;
      bus.i_qk_sel_q_o <= '0;
      bus.i_qk_sel_k_v <= '0;
      pipe_cnt         <= 0;
    end else if (bus.o_qk_ena) begin
      bus.i_qk_busy    <= 1'b1;
      bus.i_qk_vld     <= 1'b0;
      pipe_cnt         <= PIPE_LAT;
      bus.i_qk_sel_q_o <= bus.o_sel_q_o;
      bus.i_qk_sel_k_v <= (corrupt && bus.o_sel_q_o == 6'd0 && bus.o_sel_k_v == 6'd2)
                          ? 6'd3 : bus.o_sel_k_v;
    end else if (pipe_cnt != 0) begin
      pipe_cnt <= pipe_cnt - 1;
      if (pipe_cnt == 1) begin
        bus.i_qk_busy <= 1'b0;
        bus.i_qk_vld  <= 1'b1;
      end
    end else if (bus.i_qk_vld && bus.o_qk_rdy) begin
      bus.i_qk_vld <= 1'b0;
    end
  end

  int         ena_cnt;
  int         done_cnt;
  logic       busy_at_done;
  logic       err_at_done;
  logic [5:0] iss_q[$];
  logic [5:0] iss_k[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    ena_cnt  = 0;
    done_cnt = 0;
    busy_at_done = 1'b1;
    err_at_done  = 1'b0;
    iss_q.delete();
    iss_k.delete();
  endtask

  // Pulse start for one cycle; returns in the cycle after the start edge
  task automatic start_sweep(input int nq, input int nk);
    bus.i_num_q = 7'(nq);
    bus.i_num_k = 7'(nk);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  // Log issues and done pulses from the current cycle until 3 cycles past done
  task automatic run_sweep(input int budget);
    int tail;
    tail = -1;
    for (int c = 0; c < budget && tail != 0; c++) begin
      if (bus.o_qk_ena) begin
        ena_cnt++;
        iss_q.push_back(bus.o_sel_q_o);
        iss_k.push_back(bus.o_sel_k_v);
      end
      if (bus.o_done) begin
        done_cnt++;
        busy_at_done = bus.o_busy;
        err_at_done  = bus.o_err;
        tail = 3;
      end else if (tail > 0) begin
        tail--;
      end
      tick();
      bus.i_start = 1'b0;
    end
  endtask

  task automatic chk_order(input string tag, input int nq, input int nk);
    int idx;
    idx = 0;
    for (int q = 0; q < nq; q++) begin
      for (int k = 0; k < nk; k++) begin
        if (idx < iss_q.size()) begin
          chk({tag, "_q"}, 32'(iss_q[idx]), 32'(q));
          chk({tag, "_k"}, 32'(iss_k[idx]), 32'(k));
        end
        idx++;
      end
    end
  endtask

  initial begin
    int n;
    bus.i_start   = 1'b0;
    bus.i_num_q   = '0;
    bus.i_num_k   = '0;
    bus.i_res_rdy = 1'b1;
    clear_log();

    // Reset state
    repeat (3) tick();
    chk("rst_busy",    32'(bus.o_busy),    32'd0);
    chk("rst_done",    32'(bus.o_done),    32'd0);
    chk("rst_err",     32'(bus.o_err),     32'd0);
    chk("rst_ena",     32'(bus.o_qk_ena),  32'd0);
    chk("rst_res_vld", 32'(bus.o_res_vld), 32'd0);
    chk("rst_sel_q",   32'(bus.o_sel_q_o), 32'd0);
    chk("rst_sel_k",   32'(bus.o_sel_k_v), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 2x3 sweep: first issue one cycle after start despite pipeline busy/valid
    clear_log();
    start_sweep(2, 3);
    chk("a_lat_ena",  32'(bus.o_qk_ena), 32'd1);
    chk("a_busy",     32'(bus.o_busy),   32'd1);
    run_sweep(400);
    chk("a_ena_cnt",   32'(ena_cnt),      32'd6);
    chk("a_done_cnt",  32'(done_cnt),     32'd1);
    chk("a_busy_done", 32'(busy_at_done), 32'd0);
    chk("a_err",       32'(err_at_done),  32'd0);
    chk_order("a_order", 2, 3);

    // Empty sweep: done next cycle, busy for one cycle, no issue
    clear_log();
    start_sweep(0, 5);
    chk("b_busy1", 32'(bus.o_busy),   32'd1);
    chk("b_done1", 32'(bus.o_done),   32'd1);
    chk("b_ena1",  32'(bus.o_qk_ena), 32'd0);
    tick();
    chk("b_busy2", 32'(bus.o_busy),   32'd0);
    chk("b_done2", 32'(bus.o_done),   32'd0);
    run_sweep(6);
    chk("b_ena_cnt", 32'(ena_cnt), 32'd0);

    // Downstream stall on the first result
    clear_log();
    bus.i_res_rdy = 1'b0;
    start_sweep(1, 2);
    n = 0;
    while (!bus.o_res_vld && n < 40) begin
      if (bus.o_qk_ena) ena_cnt++;
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("c_res_vld", 32'(bus.o_res_vld), 32'd1);
      chk("c_res_q",   32'(bus.o_res_q),   32'd0);
      chk("c_res_k",   32'(bus.o_res_k),   32'd0);
      chk("c_qk_rdy",  32'(bus.o_qk_rdy),  32'd0);
      chk("c_no_ena",  32'(bus.o_qk_ena),  32'd0);
      tick();
    end
    chk("c_ena_held", 32'(ena_cnt), 32'd1);
    bus.i_res_rdy = 1'b1;
    #1;
    chk("c_qk_rdy_follow", 32'(bus.o_qk_rdy), 32'd1);
    run_sweep(200);
    chk("c_ena_cnt",  32'(ena_cnt),  32'd2);
    chk("c_done_cnt", 32'(done_cnt), 32'd1);

    // Tag mismatch: sticky through done, cleared by next start
    clear_log();
    corrupt = 1'b1;
    start_sweep(1, 3);
    run_sweep(300);
    chk("d_err_done",   32'(err_at_done), 32'd1);
    chk("d_err_sticky", 32'(bus.o_err),   32'd1);
    corrupt = 1'b0;
    clear_log();
    start_sweep(1, 1);
    chk("d_err_clear", 32'(bus.o_err), 32'd0);
    run_sweep(200);
    chk("d_err_done2", 32'(err_at_done), 32'd0);
    chk("d_done_cnt2", 32'(done_cnt),    32'd1);

    // Start repulsed mid-sweep with different counts is ignored
    clear_log();
    start_sweep(1, 2);
    bus.i_num_q = 7'd3;
    bus.i_num_k = 7'd3;
    bus.i_start = 1'b1;
    run_sweep(300);
    chk("e_ena_cnt",  32'(ena_cnt),  32'd2);
    chk("e_done_cnt", 32'(done_cnt), 32'd1);
    chk_order("e_order", 1, 2);

    // Async reset in S_WAIT, then no issue without a new start
    clear_log();
    start_sweep(2, 2);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_busy",    32'(bus.o_busy),    32'd0);
    chk("f_done",    32'(bus.o_done),    32'd0);
    chk("f_err",     32'(bus.o_err),     32'd0);
    chk("f_ena",     32'(bus.o_qk_ena),  32'd0);
    chk("f_res_vld", 32'(bus.o_res_vld), 32'd0);
    chk("f_res_q",   32'(bus.o_res_q),   32'd0);
    chk("f_res_k",   32'(bus.o_res_k),   32'd0);
    chk("f_sel_q",   32'(bus.o_sel_q_o), 32'd0);
    chk("f_sel_k",   32'(bus.o_sel_k_v), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 20; i++) begin
      if (bus.o_qk_ena) ena_cnt++;
      tick();
    end
    chk("f_no_ena",  32'(ena_cnt),  32'd0);
    chk("f_idle",    32'(bus.o_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mha_qk_scheduler
